// File: rtl/tlc_pkg.sv
// ============================================================================
// Module : tlc_pkg
// Brief  : Shared lamp/state encodings and phase-index width helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlc_pkg;

  localparam logic [2:0] c_lamp_red    = 3'b100;
  localparam logic [2:0] c_lamp_yellow = 3'b010;
  localparam logic [2:0] c_lamp_green  = 3'b001;
  localparam logic [2:0] c_lamp_off    = 3'b000;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_FLASH  = 2'd3
  } tlc_state_t;

  function automatic int phase_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlc_next_phase.sv
// ============================================================================
// Module : tlc_next_phase
// Brief  : Cyclic priority search for the next served phase. Demand skipping
//          is compiled in only when TLC_DEMAND_SKIP_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlc_next_phase
  import tlc_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int PH_W       = phase_idx_w(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] demand,
  input  logic [PH_W-1:0]       phase,
  output logic [PH_W-1:0]       next_phase
);

  logic [PH_W-1:0] w_rotate;

  always_comb begin
    w_rotate = (phase == PH_W'(NUM_PHASES - 1)) ? '0 : phase + PH_W'(1);
  end

`ifdef TLC_DEMAND_SKIP_EN
  logic [PH_W-1:0] w_idx;

  // Scan farthest-first so the nearest demanded phase wins; the current
  // phase (offset NUM_PHASES) is the lowest priority.
  always_comb begin
    next_phase = w_rotate;
    w_idx      = '0;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      w_idx = PH_W'((int'(phase) + k) % NUM_PHASES);
      if (demand[w_idx]) begin
        next_phase = w_idx;
      end
    end
  end
`else
  logic w_unused_demand;
  assign w_unused_demand = ^demand;
  assign next_phase      = w_rotate;
`endif

endmodule

`default_nettype wire

// File: rtl/traffic_phase_controller.sv
// ============================================================================
// Module : traffic_phase_controller
// Brief  : NUM_PHASES signal-group sequencer (green/yellow/all-red/flash).
//          Optional demand skipping via TLC_DEMAND_SKIP_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_controller
  import tlc_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int CNT_W       = 32,
  parameter int GREEN_TIME  = 50_000_000,
  parameter int YELLOW_TIME = 10_000_000,
  parameter int ALLRED_TIME = 2_000_000,
  parameter int FLASH_HALF  = 5_000_000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PHASES-1:0]                 demand,
  input  logic                                  flash_req,
  output logic [3*NUM_PHASES-1:0]               lights,
  output logic [phase_idx_w(NUM_PHASES)-1:0]    active_phase,
  output logic                                  phase_start,
  output logic                                  flashing
);

  localparam int PH_W = phase_idx_w(NUM_PHASES);

  localparam logic [CNT_W-1:0] c_green_last  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] c_allred_last = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] c_flash_last  = CNT_W'(FLASH_HALF - 1);
  localparam logic [PH_W-1:0]  c_last_phase  = PH_W'(NUM_PHASES - 1);

  tlc_state_t       r_state, w_state_nxt;
  logic [PH_W-1:0]  r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic             r_blink, w_blink_nxt;
  logic [PH_W-1:0]  w_next_phase;

  tlc_next_phase #(
    .NUM_PHASES (NUM_PHASES),
    .PH_W       (PH_W)
  ) u_next_phase (
    .demand     (demand),
    .phase      (r_phase),
    .next_phase (w_next_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ALLRED;
      r_phase <= c_last_phase;
      r_timer <= '0;
      r_blink <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_timer <= w_timer_nxt;
      r_blink <= w_blink_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_timer_nxt = r_timer + CNT_W'(1);
    w_blink_nxt = r_blink;
    case (r_state)
      ST_GREEN: begin
        if (r_timer == c_green_last) begin
          w_state_nxt = ST_YELLOW;
          w_timer_nxt = '0;
        end
      end
      ST_YELLOW: begin
        if (r_timer == c_yellow_last) begin
          w_state_nxt = ST_ALLRED;
          w_timer_nxt = '0;
        end
      end
      ST_ALLRED: begin
        if (r_timer == c_allred_last) begin
          w_timer_nxt = '0;
          if (flash_req) begin
            w_state_nxt = ST_FLASH;
            w_blink_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_GREEN;
            w_phase_nxt = w_next_phase;
          end
        end
      end
      ST_FLASH: begin
        if (!flash_req) begin
          // Park on the last phase so the following green restarts at 0.
          w_state_nxt = ST_ALLRED;
          w_phase_nxt = c_last_phase;
          w_timer_nxt = '0;
          w_blink_nxt = 1'b0;
        end else if (r_timer == c_flash_last) begin
          w_timer_nxt = '0;
          w_blink_nxt = ~r_blink;
        end
      end
      default: begin
        w_state_nxt = ST_ALLRED;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_comb begin
    lights = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      lights[3*p +: 3] = c_lamp_red;
      if (r_state == ST_FLASH) begin
        lights[3*p +: 3] = r_blink ? c_lamp_red : c_lamp_off;
      end else if (PH_W'(p) == r_phase) begin
        if (r_state == ST_GREEN) begin
          lights[3*p +: 3] = c_lamp_green;
        end else if (r_state == ST_YELLOW) begin
          lights[3*p +: 3] = c_lamp_yellow;
        end
      end
    end
  end

  assign active_phase = r_phase;
  assign phase_start  = (r_state == ST_GREEN) && (r_timer == '0);
  assign flashing     = (r_state == ST_FLASH);

endmodule

`default_nettype wire

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised multi-approach traffic signal controller. It sequences NUM_PHASES signal groups through green, yellow and all-red clearance. Phases without vehicle demand are skipped, and a flash-red mode is entered and left only at safe points. It is the next generation of our fixed two-way NS/EW controller and drives the per-approach lamp outputs of the intersection top level directly.

## Interface
- NUM_PHASES, 4, number of signal groups (2..8)
- CNT_W, 32, timer width; every *_TIME must be < 2^CNT_W
- GREEN_TIME, 50_000_000, green duration in cycles (>= 1)
- YELLOW_TIME, 10_000_000, yellow duration in cycles (>= 1)
- ALLRED_TIME, 2_000_000, all-red clearance in cycles (>= 1)
- FLASH_HALF, 5_000_000, half-period of flash blink in cycles (>= 1)

- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- demand  in  NUM_PHASES  level vehicle-detector request, one bit per phase
- flash_req  in  1  level request for flash-red mode
- lights  out  3*NUM_PHASES  per phase {R,Y,G}; phase p occupies bits [3p+2:3p]; RED=100, YELLOW=010, GREEN=001, OFF=000
- active_phase  out  $clog2(NUM_PHASES)  phase currently owning green or yellow
- phase_start  out  1  one-cycle pulse on the first green cycle of each phase
- flashing  out  1  high while in FLASH state

## Operation
- States: GREEN, YELLOW, ALLRED, FLASH. Registers: state, phase, timer (CNT_W), blink.
- Reset: state=ALLRED, phase=NUM_PHASES-1, timer=0, blink=0. All lights RED, active_phase=NUM_PHASES-1, phase_start=0, flashing=0.
- Timer counts 0..T-1 in each timed state and clears on every state change. Each state therefore lasts exactly its *_TIME cycles.
- GREEN(phase): lights[phase]=GREEN, all other phases RED. After GREEN_TIME cycles, go to YELLOW.
- YELLOW(phase): lights[phase]=YELLOW, others RED. After YELLOW_TIME cycles, go to ALLRED.
- ALLRED: all phases RED. On its last cycle, flash_req is sampled:
  - flash_req=1: go to FLASH.
  - flash_req=0: go to GREEN with phase=next_phase, and assert phase_start on that first green cycle.
- next_phase: the first index in cyclic order phase+1, phase+2, …, phase (the current phase is checked last) whose demand bit is 1, sampled on the last ALLRED cycle. If no demand bit is set, next_phase = (phase+1) mod NUM_PHASES.
- FLASH: blink toggles every FLASH_HALF cycles. All phases show RED when blink=1 and OFF when blink=0; blink starts at 1 on entry. When flash_req is sampled 0, go to ALLRED with timer=0 and phase=NUM_PHASES-1, so the next green goes to phase 0 or the first demanded phase.
- flash_req is ignored outside the last ALLRED cycle and outside FLASH. A request raised during GREEN or YELLOW waits for the normal clearance to complete.
- A demand bit that changes mid-green has no effect until the next ALLRED sample.
- At no time may more than one phase show GREEN or YELLOW.

## Timing
- Lamp outputs and active_phase are combinational decodes of the registered state and phase. There is no extra output latency.
- After rst deasserts, ALLRED lasts ALLRED_TIME cycles, then the first GREEN begins.
- Full cycle per served phase = GREEN_TIME+YELLOW_TIME+ALLRED_TIME cycles.
- rst asserted in any state takes effect on the next edge and overrides every other event.
- Phase index wrap-around is mod NUM_PHASES. The timer never wraps, because the compare at T-1 ends each state.

## Configuration
- TLC_DEMAND_SKIP_EN defined: demand-based next_phase selection as described above.
- Not defined: the demand input is ignored and next_phase is always (phase+1) mod NUM_PHASES, giving strict rotation. The demand port remains present.

## Structure
- Package tlc_pkg holds:
  - light encodings RED, YELLOW, GREEN, OFF;
  - state encodings GREEN, YELLOW, ALLRED, FLASH;
  - a phase-index width helper.
- Sub-module tlc_next_phase: combinational cyclic priority search (inputs demand and phase, output next_phase), instantiated once and compiled to rotation-only when TLC_DEMAND_SKIP_EN is absent.

## Test plan
All scenarios use NUM_PHASES=4, GREEN_TIME=8, YELLOW_TIME=3, ALLRED_TIME=2, FLASH_HALF=4.
- Reset release, demand=0, TLC_DEMAND_SKIP_EN defined -> 2 cycles all-RED; phase 0 GREEN for 8 cycles with phase_start on its first cycle; YELLOW 3; all-RED 2; then phase 1 GREEN, continuing in rotation 0→1→2→3→0.
- demand=4'b1000 held during phase 0 green -> after clearance, phase 3 GREEN; phases 1 and 2 never lit.
- demand=4'b0001 only, while phase 0 is active -> phase 0 re-served after ALLRED (current phase checked last), with phase_start pulsing again.
- flash_req raised mid-green of phase 1 -> green and yellow complete, 2 all-RED cycles, then FLASH with lights alternating RED/OFF every 4 cycles and flashing=1. Dropping flash_req -> ALLRED 2 cycles, then phase 0 GREEN.
- rst pulsed for 1 cycle during YELLOW of phase 2 -> next cycle all RED with active_phase=3; sequence restarts exactly as after power-up.
- Built without TLC_DEMAND_SKIP_EN and demand=4'b1000 -> strict rotation 0→1→2→3.
